// File: rtl/key_debounce_pkg.sv
// Shared key-filter definitions: FSM state encoding and
// default filter lengths, reused by future multi-key blocks.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_FILT = 2'd1,
    DOWN       = 2'd2,
    REL_FILT   = 2'd3
  } key_state_t;

  localparam int unsigned CNT_20MS_50M = 999_999;
  localparam int unsigned CNT_SIM      = 19;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single async bit.
// Both flops reset to RST_VAL so the output is quiet after reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // two-stage capture of the asynchronous input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Push-button debouncer: sync, bounce filter, level + press strobe.
// Define KEY_DEBOUNCE_RELEASE_EN to add the key_release strobe port.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned CNT_MAX  = CNT_20MS_50M,
  parameter logic        KEY_IDLE = 1'b1
) (
  input  logic sys_clk,
  input  logic sys_rest_n,
  input  logic key_in,
`ifdef KEY_DEBOUNCE_RELEASE_EN
  output logic key_release,
`endif
  output logic key_pressed,
  output logic key_flag
);

  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

  key_state_t    state;
  logic [CW-1:0] cnt;
  logic          key_s;
  logic          key_act;

  sync_2ff #(
    .RST_VAL (KEY_IDLE)
  ) u_sync (
    .clk   (sys_clk),
    .rst_n (sys_rest_n),
    .d     (key_in),
    .q     (key_s)
  );

  assign key_act = (key_s != KEY_IDLE);

  // filter FSM with stability counter and registered strobes
  always_ff @(posedge sys_clk or negedge sys_rest_n) begin
    if (!sys_rest_n) begin
      state       <= IDLE;
      cnt         <= '0;
      key_pressed <= 1'b0;
      key_flag    <= 1'b0;
`ifdef KEY_DEBOUNCE_RELEASE_EN
      key_release <= 1'b0;
`endif
    end else begin
      key_flag <= 1'b0;
`ifdef KEY_DEBOUNCE_RELEASE_EN
      key_release <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (key_act) begin
            state <= PRESS_FILT;
            cnt   <= '0;
          end
        end
        PRESS_FILT: begin
          if (!key_act) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state       <= DOWN;
            cnt         <= '0;
            key_pressed <= 1'b1;
            key_flag    <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DOWN: begin
          if (!key_act) begin
            state <= REL_FILT;
            cnt   <= '0;
          end
        end
        REL_FILT: begin
          if (key_act) begin
            state <= DOWN;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state       <= IDLE;
            cnt         <= '0;
            key_pressed <= 1'b0;
`ifdef KEY_DEBOUNCE_RELEASE_EN
            key_release <= 1'b1;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with a 19-cycle filter.
// Strobe counts come from a negedge monitor.
module tb_key_debounce;
  import key_debounce_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_in = 1'b1;
  logic key_pressed;
  logic key_flag;
  logic key_release_w;

  int checks = 0;
  int errors = 0;
  int flag_cnt = 0;
  int rel_cnt = 0;
  int dbl = 0;
  int overlap = 0;
  logic prev_flag = 1'b0;
  int f0;
  int r0;

  always #10 clk = ~clk;

  key_debounce #(
    .CNT_MAX  (CNT_SIM),
    .KEY_IDLE (1'b1)
  ) dut (
    .sys_clk     (clk),
    .sys_rest_n  (rst_n),
    .key_in      (key_in),
`ifdef KEY_DEBOUNCE_RELEASE_EN
    .key_release (key_release_w),
`endif
    .key_pressed (key_pressed),
    .key_flag    (key_flag)
  );

`ifndef KEY_DEBOUNCE_RELEASE_EN
  assign key_release_w = 1'b0;
`endif

  always @(negedge clk) begin
    if (key_flag) flag_cnt++;
    if (key_release_w) rel_cnt++;
    if (key_flag && prev_flag) dbl++;
    if (key_flag && key_release_w) overlap++;
    prev_flag = key_flag;
  end

  task automatic check(input string tag,
                       input int got,
                       input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic release_key();
    @(negedge clk);
    key_in = 1'b1;
    edges(45);
  endtask

  initial begin
    // 1: reset held with random pin activity
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      key_in = 1'($urandom);
      check("rst_pressed", int'(key_pressed), 0);
    end
    check("rst_flag", int'(key_flag), 0);
    @(negedge clk);
    key_in = 1'b1;
    rst_n = 1'b1;
    edges(30);
    check("post_rst_pressed", int'(key_pressed), 0);
    check("post_rst_flags", flag_cnt, 0);

    // 2: clean press
    @(negedge clk);
    key_in = 1'b0;
    f0 = flag_cnt;
    edges(21);
    check("press_e21_pressed", int'(key_pressed), 0);
    check("press_e21_flag", int'(key_flag), 0);
    edges(1);
    check("press_e22_pressed", int'(key_pressed), 1);
    check("press_e22_flag", int'(key_flag), 1);
    edges(1);
    check("press_e23_flag", int'(key_flag), 0);
    edges(17);
    check("press_one_flag", flag_cnt - f0, 1);
    check("press_held", int'(key_pressed), 1);

    // 4: release
    @(negedge clk);
    key_in = 1'b1;
    f0 = flag_cnt;
    r0 = rel_cnt;
    edges(21);
    check("rel_e21_pressed", int'(key_pressed), 1);
    edges(1);
    check("rel_e22_pressed", int'(key_pressed), 0);
`ifdef KEY_DEBOUNCE_RELEASE_EN
    check("rel_e22_strobe", int'(key_release_w), 1);
    edges(1);
    check("rel_e23_strobe", int'(key_release_w), 0);
    edges(17);
    check("rel_one_strobe", rel_cnt - r0, 1);
`else
    edges(18);
`endif
    check("rel_no_flag", flag_cnt - f0, 0);

    // 3: bounce before settling low
    f0 = flag_cnt;
    @(negedge clk);
    key_in = 1'b0;
    repeat (10) @(negedge clk);
    key_in = 1'b1;
    repeat (3) @(negedge clk);
    key_in = 1'b0;
    edges(21);
    check("bnc_e21_flags", flag_cnt - f0, 0);
    check("bnc_e21_pressed", int'(key_pressed), 0);
    edges(1);
    check("bnc_e22_flag", int'(key_flag), 1);
    edges(18);
    check("bnc_one_flag", flag_cnt - f0, 1);
    release_key();
    check("bnc_released", int'(key_pressed), 0);

    // 5: reset in the middle of the press filter
    @(negedge clk);
    key_in = 1'b0;
    f0 = flag_cnt;
    edges(13);
    rst_n = 1'b0;
    #1;
    check("mid_rst_pressed", int'(key_pressed), 0);
    check("mid_rst_flag", int'(key_flag), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    edges(21);
    check("mid_e21_flags", flag_cnt - f0, 0);
    check("mid_e21_pressed", int'(key_pressed), 0);
    edges(1);
    check("mid_e22_flag", int'(key_flag), 1);
    check("mid_e22_pressed", int'(key_pressed), 1);
    release_key();

    // 6: random chatter, then one clean press
    f0 = flag_cnt;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      key_in = 1'($urandom);
    end
    @(negedge clk);
    key_in = 1'b1;
    edges(30);
    check("rnd_no_flag", flag_cnt - f0, 0);
    @(negedge clk);
    key_in = 1'b0;
    edges(40);
    check("rnd_clean_flag", flag_cnt - f0, 1);
    check("rnd_clean_pressed", int'(key_pressed), 1);
    release_key();
    check("never_double", dbl, 0);
    check("never_overlap", overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
